shift_deserializer: RTL and testbench

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

---
 rtl/shift_deserializer_pkg.sv | 13 +
 rtl/shift_deserializer_word_hold.sv | 42 ++++
 rtl/shift_deserializer.sv | 104 ++++++++++
 tb/tb_shift_deserializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STALL   = 2'd2
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_word_hold.sv
// Output holding register: captures a finished word and tracks whether it is still unconsumed.
module word_hold_reg #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         take,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data,
  output logic         valid
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // A load wins over a take on the same edge so back-to-back words never bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end else if (take && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out deserializer with per-word bit order and a ready/valid output word.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sin,
  input  logic         sin_valid,
  output logic         sin_ready,
  input  logic         dir,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic          dir_q, dir_d;

  logic          accept;
  logic          first_bit;
  logic          last_bit;
  logic          dir_eff;
  logic [N-1:0]  shifted;
  logic          hold_load;
  logic [N-1:0]  hold_data;
  logic          take;

  assign accept    = sin_valid && sin_ready;
  assign first_bit = (count_q == '0);
  assign last_bit  = (count_q == CW'(N - 1));
  assign take      = out_valid && out_ready;
  // The first bit of a word uses the live dir; later bits use the latched one.
  assign dir_eff   = first_bit ? dir : dir_q;
  assign shifted   = (dir_eff == DIR_LSB_FIRST) ? {sin, sreg_q[N-1:1]}
                                                : {sreg_q[N-2:0], sin};

  always_comb begin
    dir_d     = dir_q;
    sreg_d    = sreg_q;
    count_d   = count_q;
    hold_load = 1'b0;
    hold_data = shifted;
    if (accept) begin
      if (first_bit) dir_d = dir;
      sreg_d  = shifted;
      count_d = count_q + CW'(1);
      if (last_bit && (!out_valid || out_ready)) begin
        hold_load = 1'b1;
        count_d   = '0;
      end
    end else if ((state_q == ST_STALL) && take) begin
      hold_load = 1'b1;
      hold_data = sreg_q;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sreg_q  <= '0;
      dir_q   <= DIR_MSB_FIRST;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_COLLECT;
      ST_COLLECT: if (accept && last_bit) state_d = hold_load ? ST_IDLE : ST_STALL;
      ST_STALL:   if (take) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sin_ready = (state_q != ST_STALL);
    busy      = (count_q != '0);
  end

  word_hold_reg #(.N(N)) u_hold (
    .clk     (clk),
    .clr     (clr),
    .load    (hold_load),
    .take    (out_ready),
    .data_in (hold_data),
    .data    (out),
    .valid   (out_valid)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (N=4): vector table plus hand sequences for stall and clear.
module tb_shift_deserializer;

  typedef struct {
    logic       clr;
    logic       sv;
    logic       s;
    logic       d;
    logic       ordy;
    logic [3:0] e_out;
    logic       e_ov;
    logic       e_sr;
    logic       e_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       sin;
  logic       sin_valid;
  logic       sin_ready;
  logic       dir;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  shift_deserializer #(.N(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready),
    .dir       (dir),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic c, logic sv, logic s, logic d, logic ordy,
                              logic [3:0] eo, logic eov, logic esr, logic eb);
    vec_t v;
    v.clr = c; v.sv = sv; v.s = s; v.d = d; v.ordy = ordy;
    v.e_out = eo; v.e_ov = eov; v.e_sr = esr; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] eo, input logic eov,
                     input logic esr, input logic eb);
    total += 4;
    if (out !== eo) begin
      bad++; $display("FAIL %s out: got %b want %b", name, out, eo);
    end
    if (out_valid !== eov) begin
      bad++; $display("FAIL %s out_valid: got %b want %b", name, out_valid, eov);
    end
    if (sin_ready !== esr) begin
      bad++; $display("FAIL %s sin_ready: got %b want %b", name, sin_ready, esr);
    end
    if (busy !== eb) begin
      bad++; $display("FAIL %s busy: got %b want %b", name, busy, eb);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the next rising edge.
  task automatic cyc(input logic sv, input logic s, input logic d, input logic ordy);
    @(negedge clk);
    sin_valid = sv; sin = s; dir = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset", 4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    // MSB-first 1,0,1,1
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b1011, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'b1011, 0, 1, 0));
    // LSB-first 1,0,1,1 with dir flipped mid-word
    tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1011, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 4'b1011, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b1011, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b1101, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'b1101, 0, 1, 0));
    // MSB-first 0,1,1,0 with idle gaps; hold then take
    tbl.push_back(mk(0, 1, 0, 0, 1, 4'b1101, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 4'b1101, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b1101, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4'b1101, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b1101, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'b1101, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4'b0110, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0110, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'b0110, 0, 1, 0));
    // two bits, clear, then fresh MSB-first 1,0,0,1
    tbl.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'b1001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'b1001, 0, 1, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      clr = tbl[i].clr; sin_valid = tbl[i].sv; sin = tbl[i].s;
      dir = tbl[i].d;   out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_ov, tbl[i].e_sr, tbl[i].e_busy);
    end

    // Stall: second word completes while first is still unconsumed.
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("stall_w1", 4'b1111, 1, 1, 0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("stall_full", 4'b1111, 1, 0, 1);
    cyc(1, 1, 0, 0);
    chk("stall_9th", 4'b1111, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk("stall_release", 4'b0000, 1, 1, 0);
    cyc(0, 0, 0, 1);
    chk("stall_drain", 4'b0000, 0, 1, 0);

    // Nth bit lands on the same edge the previous word is taken; then one more word back-to-back.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("b2b_w1", 4'b1000, 1, 1, 0);
    cyc(1, 0, 0, 0); chk("b2b_b1", 4'b1000, 1, 1, 1);
    cyc(1, 1, 0, 0); chk("b2b_b2", 4'b1000, 1, 1, 1);
    cyc(1, 1, 0, 0); chk("b2b_b3", 4'b1000, 1, 1, 1);
    cyc(1, 1, 0, 1); chk("b2b_w2", 4'b0111, 1, 1, 0);
    cyc(1, 1, 0, 1); chk("b2b_w3b1", 4'b0111, 0, 1, 1);
    cyc(1, 1, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    chk("b2b_w3", 4'b1100, 1, 1, 0);

    // Asynchronous clear with a valid word and a partial word held.
    cyc(1, 1, 0, 0);
    chk("clr_pre", 4'b1100, 1, 1, 1);
    @(negedge clk);
    sin_valid = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_async", 4'b0000, 0, 1, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_release", 4'b0000, 0, 1, 0);
    cyc(1, 0, 1, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 1, 1);
    chk("clr_fresh", 4'b1110, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
